// File: rtl/pipTypes.sv
// Shared pipeline types: forwarding selects and the per-stage hazard slot.
package pipTypes;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE       = 2'd0,
    FWD_FROM_EXMEM = 2'd1,
    FWD_FROM_MEMWB = 2'd2
  } fwd_t;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wr_valid;
    logic             load;
  } hazard_slot_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one source operand against the ex and mem slots and picks the nearest producer.
module fwd_match
  import pipTypes::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             src_valid,
  input  hazard_slot_t     ex_slot,
  input  hazard_slot_t     mem_slot,
  output fwd_t             sel
);

  // Nearest producer first; a load still in ex cannot forward, the hazard logic stalls instead.
  always_comb begin
    sel = FWD_NONE;
    if (src_valid && ex_slot.wr_valid && !ex_slot.load && (src == ex_slot.dest)) begin
      sel = FWD_FROM_EXMEM;
    end else if (src_valid && mem_slot.wr_valid && (src == mem_slot.dest)) begin
      sel = FWD_FROM_MEMWB;
    end else begin
      sel = FWD_NONE;
    end
  end

endmodule

// File: rtl/fwd_ctl.sv
// Forwarding-select and load-use hazard controller for the five-stage pipeline.
module fwd_ctl
  import pipTypes::*;
#(
  parameter int NREGS = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     pipe_stall,
  input  logic                     id_valid,
  input  logic [$clog2(NREGS)-1:0] id_A_reg,
  input  logic                     id_A_reg_valid,
  input  logic [$clog2(NREGS)-1:0] id_B_reg,
  input  logic                     id_B_reg_valid,
  input  logic [$clog2(NREGS)-1:0] id_dest_reg,
  input  logic                     id_dest_reg_valid,
  input  logic                     id_load_inst,
  output fwd_t                     A_fwd_from,
  output fwd_t                     B_fwd_from,
  output logic                     stall_id,
  output logic                     bubble_ex
);

  // Producers three or more stages ahead are covered by register-file
  // write-before-read, so the wb slot needs no state here.
  hazard_slot_t ex_r;
  hazard_slot_t mem_r;
  fwd_t         a_fwd_r;
  fwd_t         b_fwd_r;
  logic         bubble_r;

  hazard_slot_t id_slot_s;
  hazard_slot_t ex_next_s;
  logic         stall_id_s;
  logic         insert_bubble_s;
  fwd_t         a_sel_s;
  fwd_t         b_sel_s;
  fwd_t         a_next_s;
  fwd_t         b_next_s;

  // Decode the ID instruction into a slot and detect a load-use hazard against ex.
  always_comb begin
    id_slot_s.dest     = id_dest_reg;
    id_slot_s.wr_valid = id_dest_reg_valid & id_valid & (id_dest_reg != 5'd0);
    id_slot_s.load     = id_load_inst & id_valid;
    stall_id_s = id_valid & ex_r.wr_valid & ex_r.load &
                 ((id_A_reg_valid & (id_A_reg == ex_r.dest)) |
                  (id_B_reg_valid & (id_B_reg == ex_r.dest)));
    insert_bubble_s = stall_id_s | ~id_valid;
  end

  fwd_match u_match_a (
    .src       (id_A_reg),
    .src_valid (id_A_reg_valid),
    .ex_slot   (ex_r),
    .mem_slot  (mem_r),
    .sel       (a_sel_s)
  );

  fwd_match u_match_b (
    .src       (id_B_reg),
    .src_valid (id_B_reg_valid),
    .ex_slot   (ex_r),
    .mem_slot  (mem_r),
    .sel       (b_sel_s)
  );

  // A bubble entering EX carries an empty slot and no forwarding.
  always_comb begin
    ex_next_s = '0;
    a_next_s  = FWD_NONE;
    b_next_s  = FWD_NONE;
    if (insert_bubble_s) begin
      ex_next_s = '0;
      a_next_s  = FWD_NONE;
      b_next_s  = FWD_NONE;
    end else begin
      ex_next_s = id_slot_s;
      a_next_s  = a_sel_s;
      b_next_s  = b_sel_s;
    end
  end

  // Slot advance and registered selects; pipe_stall freezes everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_r     <= '0;
      mem_r    <= '0;
      a_fwd_r  <= FWD_NONE;
      b_fwd_r  <= FWD_NONE;
      bubble_r <= 1'b1;
    end else if (!pipe_stall) begin
      mem_r    <= ex_r;
      ex_r     <= ex_next_s;
      a_fwd_r  <= a_next_s;
      b_fwd_r  <= b_next_s;
      bubble_r <= insert_bubble_s;
    end else begin
      mem_r    <= mem_r;
      ex_r     <= ex_r;
      a_fwd_r  <= a_fwd_r;
      b_fwd_r  <= b_fwd_r;
      bubble_r <= bubble_r;
    end
  end

  assign A_fwd_from = a_fwd_r;
  assign B_fwd_from = b_fwd_r;
  assign bubble_ex  = bubble_r;
  assign stall_id   = stall_id_s;

endmodule

// File: tb/tb_fwd_ctl.sv
// Directed testbench for fwd_ctl with hand-computed expected selects and stalls.
module tb_fwd_ctl;
  import pipTypes::*;

  logic       clock;
  logic       reset;
  logic       pipe_stall;
  logic       id_valid;
  logic [4:0] id_A_reg;
  logic       id_A_reg_valid;
  logic [4:0] id_B_reg;
  logic       id_B_reg_valid;
  logic [4:0] id_dest_reg;
  logic       id_dest_reg_valid;
  logic       id_load_inst;
  fwd_t       A_fwd_from;
  fwd_t       B_fwd_from;
  logic       stall_id;
  logic       bubble_ex;

  int n_checks;
  int n_errors;

  fwd_ctl #(.NREGS(32)) dut (
    .clock             (clock),
    .reset             (reset),
    .pipe_stall        (pipe_stall),
    .id_valid          (id_valid),
    .id_A_reg          (id_A_reg),
    .id_A_reg_valid    (id_A_reg_valid),
    .id_B_reg          (id_B_reg),
    .id_B_reg_valid    (id_B_reg_valid),
    .id_dest_reg       (id_dest_reg),
    .id_dest_reg_valid (id_dest_reg_valid),
    .id_load_inst      (id_load_inst),
    .A_fwd_from        (A_fwd_from),
    .B_fwd_from        (B_fwd_from),
    .stall_id          (stall_id),
    .bubble_ex         (bubble_ex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a, input logic av,
                        input logic [4:0] b, input logic bv,
                        input logic [4:0] d, input logic dv, input logic ld);
    id_valid          = v;
    id_A_reg          = a;
    id_A_reg_valid    = av;
    id_B_reg          = b;
    id_B_reg_valid    = bv;
    id_dest_reg       = d;
    id_dest_reg_valid = dv;
    id_load_inst      = ld;
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    pipe_stall = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    check("rst_a", A_fwd_from, FWD_NONE);
    check("rst_b", B_fwd_from, FWD_NONE);
    check("rst_bubble", bubble_ex, 1'b1);
    check("rst_stall", stall_id, 1'b0);

    // addu r3 <- r1,r2 ; addu r7 <- r3,r6
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    check("t1_stall0", stall_id, 1'b0);
    step();
    check("t1_first_bubble", bubble_ex, 1'b0);
    set_id(1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0);
    check("t1_stall1", stall_id, 1'b0);
    step();
    check("t1_a_exmem", A_fwd_from, FWD_FROM_EXMEM);
    check("t1_b_none", B_fwd_from, FWD_NONE);

    // addu r3 ; unrelated r10 ; reader of r3 on B
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd11, 1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0);
    step();
    check("t2_b_memwb", B_fwd_from, FWD_FROM_MEMWB);
    check("t2_a_none", A_fwd_from, FWD_NONE);

    // lw r5 ; immediate reader of r5
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 1'b0);
    check("t3_stall", stall_id, 1'b1);
    step();
    check("t3_bubble", bubble_ex, 1'b1);
    check("t3_bubble_a", A_fwd_from, FWD_NONE);
    check("t3_stall_drop", stall_id, 1'b0);
    step();
    check("t3_consumer_bubble", bubble_ex, 1'b0);
    check("t3_a_memwb", A_fwd_from, FWD_FROM_MEMWB);
    check("t3_b_none", B_fwd_from, FWD_NONE);

    // addu r4 ; addu r4 ; reader of r4 on both operands
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd4, 1'b1, 5'd4, 1'b1, 5'd20, 1'b1, 1'b0);
    step();
    check("t4_a_nearest", A_fwd_from, FWD_FROM_EXMEM);
    check("t4_b_nearest", B_fwd_from, FWD_FROM_EXMEM);

    // writer of r0 ; reader of r0 (dest r15)
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd15, 1'b1, 1'b0);
    step();
    check("t5_a_r0", A_fwd_from, FWD_NONE);
    check("t5_b_r0", B_fwd_from, FWD_NONE);

    // lw r5 <- r15 (forwarded from ex) ; reader of r5 ; pipe_stall for 3 cycles
    set_id(1'b1, 5'd15, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    step();
    check("t6_lw_a", A_fwd_from, FWD_FROM_EXMEM);
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 1'b0);
    check("t6_stall", stall_id, 1'b1);
    pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_frozen_stall", stall_id, 1'b1);
      check("t6_frozen_bubble", bubble_ex, 1'b0);
      check("t6_frozen_a", A_fwd_from, FWD_FROM_EXMEM);
    end
    pipe_stall = 1'b0;
    #1;
    step();
    check("t6_one_bubble", bubble_ex, 1'b1);
    check("t6_bubble_a", A_fwd_from, FWD_NONE);
    check("t6_stall_clear", stall_id, 1'b0);
    step();
    check("t6_consumer", bubble_ex, 1'b0);
    check("t6_a_memwb", A_fwd_from, FWD_FROM_MEMWB);

    // lw r6 ; reader of r6 on B ; reset while stalled
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd9, 1'b1, 5'd6, 1'b1, 5'd17, 1'b1, 1'b0);
    check("t7_stall", stall_id, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("t7_stall_dropped", stall_id, 1'b0);
    check("t7_a_none", A_fwd_from, FWD_NONE);
    check("t7_b_none", B_fwd_from, FWD_NONE);
    check("t7_bubble", bubble_ex, 1'b1);

    // consumer now proceeds without a stall; then an invalid ID slot becomes a bubble
    step();
    check("t7_proceed", bubble_ex, 1'b0);
    set_id(1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    step();
    check("t8_invalid_bubble", bubble_ex, 1'b1);
    check("t8_invalid_a", A_fwd_from, FWD_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
